// File: rtl/xnor_cmp_sched_if.sv
// Client-side bundle for the bit-serial XNOR compare scheduler.
// Clients drive requests and operands; the scheduler returns grant, status and results.
interface xnor_cmp_sched_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             equal;
  logic [CW-1:0]    match_cnt;

  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, busy, done, done_id, equal, match_cnt
  );

  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, busy, done, done_id, equal, match_cnt
  );
endinterface

// File: rtl/xnor_cmp_sched.sv
// Round-robin scheduler for two clients sharing one XNOR bit cell; compares
// the granted operand pair LSB-first, one bit per clock, and counts matches.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a ^ b);
endmodule

module xnor_cmp_sched #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  xnor_cmp_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic             last;
  logic             cur;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [BW-1:0]    bitcnt;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    acc_next;
  logic             y;
  logic             pick;

  xnor_gate u_cell (
    .a (sa[0]),
    .b (sb[0]),
    .y (y)
  );

  // On a tie the client that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req == 2'b11)
      pick = ~last;
    else if (bus.req[1])
      pick = 1'b1;
  end

  assign acc_next = acc + CW'(y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      cur           <= 1'b0;
      sa            <= '0;
      sb            <= '0;
      bitcnt        <= '0;
      acc           <= '0;
      bus.gnt       <= 2'b00;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.done_id   <= 1'b0;
      bus.equal     <= 1'b0;
      bus.match_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.gnt  <= 2'b00;
          bus.done <= 1'b0;
          if (bus.req != 2'b00) begin
            cur      <= pick;
            last     <= pick;
            sa       <= pick ? bus.a1 : bus.a0;
            sb       <= pick ? bus.b1 : bus.b0;
            bitcnt   <= '0;
            acc      <= '0;
            bus.gnt  <= pick ? 2'b10 : 2'b01;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bus.gnt  <= 2'b00;
          bus.done <= 1'b0;
          acc      <= acc_next;
          sa       <= sa >> 1;
          sb       <= sb >> 1;
          bitcnt   <= bitcnt + 1'b1;
          // Last bit: publish using the count that includes this cycle's bit.
          if (bitcnt == BW'(WIDTH - 1)) begin
            bus.match_cnt <= acc_next;
            bus.equal     <= (acc_next == CW'(WIDTH));
            bus.done_id   <= cur;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
